// File: rtl/bus_serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, N data bits MSB-first,
// even parity and stop bit, each held for CLKS_PER_BIT clocks.
module bus_serial_frame_tx #(
  parameter int unsigned PARELLEL_PORT_WIDTH = 14,
  parameter int unsigned CLKS_PER_BIT        = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PARELLEL_PORT_WIDTH-1:0] din,
  input  logic [3:0]                     bit_lngt,
  input  logic                           din_valid,
  output logic                           din_ready,
  output logic                           serial_out,
  output logic                           tx_active,
  output logic                           done,
  output logic                           err
);

  localparam int unsigned W     = PARELLEL_PORT_WIDTH;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       shreg_q, shreg_d;
  logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic               parity_q, parity_d;
  logic               serial_out_q, serial_out_d;
  logic               tx_active_q, tx_active_d;
  logic               din_ready_q, din_ready_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               xfer_c;
  logic               legal_c;
  logic               bit_end_c;
  logic [W-1:0]       mask_c;
  logic [W-1:0]       aligned_c;

  // Word alignment and parity of the selected low N bits.
  always_comb begin
    mask_c    = ~({W{1'b1}} << bit_lngt);
    aligned_c = din << (32'(W) - 32'(bit_lngt));
    legal_c   = (bit_lngt != '0) && (32'(bit_lngt) <= 32'(W));
    xfer_c    = din_valid && din_ready_q;
    bit_end_c = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      clk_cnt_q    <= '0;
      parity_q     <= 1'b0;
      serial_out_q <= 1'b1;
      tx_active_q  <= 1'b0;
      din_ready_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      clk_cnt_q    <= clk_cnt_d;
      parity_q     <= parity_d;
      serial_out_q <= serial_out_d;
      tx_active_q  <= tx_active_d;
      din_ready_q  <= din_ready_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    clk_cnt_d = '0;
    parity_d  = parity_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer_c) begin
          if (legal_c) begin
            state_d   = START;
            shreg_d   = aligned_c;
            bit_cnt_d = bit_lngt;
            parity_d  = ^(din & mask_c);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      START: begin
        if (bit_end_c) state_d = DATA;
      end
      DATA: begin
        if (bit_end_c) begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q - LEN_W'(1);
          if (bit_cnt_q == LEN_W'(1)) state_d = PARITY;
        end
      end
      PARITY: begin
        if (bit_end_c) state_d = STOP;
      end
      STOP: begin
        if (bit_end_c) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clock counter runs 0..CLKS_PER_BIT-1 in every on-line state.
    if (state_q != IDLE) begin
      clk_cnt_d = bit_end_c ? '0 : clk_cnt_q + CNT_W'(1);
    end

    // Registered line outputs follow the state being entered.
    case (state_d)
      START:   serial_out_d = 1'b0;
      DATA:    serial_out_d = shreg_d[W-1];
      PARITY:  serial_out_d = parity_d;
      default: serial_out_d = 1'b1;
    endcase
    tx_active_d = (state_d != IDLE);
    din_ready_d = (state_d == IDLE);
  end

  assign din_ready  = din_ready_q;
  assign serial_out = serial_out_q;
  assign tx_active  = tx_active_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bus_serial_frame_tx.sv
// Scoreboard bench: lane 0 runs CLKS_PER_BIT=1, lane 1 runs CLKS_PER_BIT=3.
module tb_bus_serial_frame_tx;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [13:0] din_a   [2];
  logic [3:0]  len_a   [2];
  logic        valid_a [2];
  logic        rd [2];
  logic        so [2];
  logic        ta [2];
  logic        dn [2];
  logic        er [2];

  exp_t        q [2][$];
  logic        pend [2];
  int          done_seen [2];
  int          err_seen [2];
  int          n_checks;
  int          n_pass;
  logic        mon_en;

  bus_serial_frame_tx #(.PARELLEL_PORT_WIDTH(14), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din_a[0]), .bit_lngt(len_a[0]), .din_valid(valid_a[0]),
    .din_ready(rd[0]), .serial_out(so[0]), .tx_active(ta[0]), .done(dn[0]), .err(er[0])
  );

  bus_serial_frame_tx #(.PARELLEL_PORT_WIDTH(14), .CLKS_PER_BIT(3)) u_dut3 (
    .clk(clk), .rst(rst), .din(din_a[1]), .bit_lngt(len_a[1]), .din_valid(valid_a[1]),
    .din_ready(rd[1]), .serial_out(so[1]), .tx_active(ta[1]), .done(dn[1]), .err(er[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Queue one expected frame: pattern bits sent MSB first, each cpb times.
  task automatic push_pat(input int lane, input logic [31:0] pat, input int nbits, input int cpb);
    exp_t e;
    for (int i = nbits - 1; i >= 0; i--) begin
      for (int c = 0; c < cpb; c++) begin
        e.b    = pat[i];
        e.last = (i == 0) && (c == cpb - 1);
        q[lane].push_back(e);
      end
    end
  endtask

  task automatic wait_ready(input int lane);
    int n;
    n = 0;
    while (!rd[lane] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rd[lane]) chk("ready_timeout", 32'(rd[lane]), 32'd1);
  endtask

  task automatic issue(input int lane, input logic [13:0] d, input logic [3:0] n);
    wait_ready(lane);
    din_a[lane]   = d;
    len_a[lane]   = n;
    valid_a[lane] = 1'b1;
    @(posedge clk); #1;
    valid_a[lane] = 1'b0;
  endtask

  task automatic wait_drain(input int lane);
    int n;
    n = 0;
    while ((q[lane].size() != 0 || ta[lane]) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'(q[lane].size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expected bit per active cycle and tracks the done pulse.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      for (int i = 0; i < 2; i++) begin
        logic old;
        exp_t e;
        old = pend[i];
        pend[i] = 1'b0;
        chk(i == 0 ? "done_l1" : "done_l3", 32'(dn[i]), 32'(old));
        if (old) chk("tx_active_at_done", 32'(ta[i]), 32'd0);
        if (dn[i]) done_seen[i]++;
        if (er[i]) err_seen[i]++;
        if (dn[i] || er[i]) chk("done_err_exclusive", 32'(dn[i] & er[i]), 32'd0);
        if (ta[i]) begin
          if (q[i].size() == 0) begin
            chk("tx_active_without_expectation", 32'(ta[i]), 32'd0);
          end else begin
            e = q[i].pop_front();
            chk(i == 0 ? "serial_l1" : "serial_l3", 32'(so[i]), 32'(e.b));
            pend[i] = e.last;
          end
        end else begin
          chk("idle_line", 32'(so[i]), 32'd1);
        end
      end
    end
  end

  initial begin
    int nd;
    n_checks = 0;
    n_pass   = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din_a[i] = '0; len_a[i] = '0; valid_a[i] = 1'b0;
      pend[i] = 1'b0; done_seen[i] = 0; err_seen[i] = 0;
    end

    // Reset then idle.
    repeat (2) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        chk("rst_serial_out", 32'(so[i]), 32'd1);
        chk("rst_din_ready", 32'(rd[i]), 32'd1);
        chk("rst_tx_active", 32'(ta[i]), 32'd0);
        chk("rst_done", 32'(dn[i]), 32'd0);
        chk("rst_err", 32'(er[i]), 32'd0);
      end
    end
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 0xA5, N=8: 0,10100101,0,1
    push_pat(0, 32'b0_10100101_0_1, 11, 1);
    issue(0, 14'h00A5, 4'd8);
    wait_drain(0);

    // 0x3FFF, N=14, three clocks per bit: 51 cycles.
    push_pat(1, 32'b0_11111111111111_0_1, 17, 3);
    issue(1, 14'h3FFF, 4'd14);
    wait_drain(1);

    // Illegal lengths: consumed in one cycle, err pulse, line stays idle.
    issue(0, 14'h0055, 4'd0);
    chk("err_len0", 32'(er[0]), 32'd1);
    chk("ready_after_len0", 32'(rd[0]), 32'd1);
    chk("line_after_len0", 32'(so[0]), 32'd1);
    @(posedge clk); #1;
    chk("err_len0_one_cycle", 32'(er[0]), 32'd0);
    issue(0, 14'h0055, 4'd15);
    chk("err_len15", 32'(er[0]), 32'd1);
    chk("active_after_len15", 32'(ta[0]), 32'd0);
    @(posedge clk); #1;
    chk("err_len15_one_cycle", 32'(er[0]), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back N=1 frames of 0x0001: 0,1,1,1 then one idle cycle.
    for (int k = 0; k < 3; k++) push_pat(0, 32'b0111, 4, 1);
    wait_ready(0);
    din_a[0] = 14'h0001; len_a[0] = 4'd1; valid_a[0] = 1'b1;
    nd = 0;
    for (int c = 0; c < 100 && nd < 3; c++) begin
      @(posedge clk); #1;
      if (dn[0]) begin
        nd++;
        if (nd == 3) begin
          valid_a[0] = 1'b0;
        end else begin
          @(posedge clk); #1;
          chk("b2b_start_after_one_idle", 32'(so[0]), 32'd0);
          chk("b2b_active_after_one_idle", 32'(ta[0]), 32'd1);
        end
      end
    end
    valid_a[0] = 1'b0;
    chk("b2b_frames_done", 32'(nd), 32'd3);
    wait_drain(0);

    // Reset during DATA of 0xA5, then a clean frame.
    push_pat(0, 32'b0_10100101_0_1, 11, 1);
    issue(0, 14'h00A5, 4'd8);
    repeat (2) @(posedge clk);
    #1;
    chk("midframe_active_before_rst", 32'(ta[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q[0].delete();
    pend[0] = 1'b0;
    chk("midrst_serial_out", 32'(so[0]), 32'd1);
    chk("midrst_tx_active", 32'(ta[0]), 32'd0);
    chk("midrst_done", 32'(dn[0]), 32'd0);
    chk("midrst_din_ready", 32'(rd[0]), 32'd1);
    push_pat(0, 32'b0_10100101_0_1, 11, 1);
    issue(0, 14'h00A5, 4'd8);
    chk("after_rst_start_bit", 32'(so[0]), 32'd0);
    wait_drain(0);

    chk("err_count_l1", 32'(err_seen[0]), 32'd2);
    chk("done_count_l1", 32'(done_seen[0]), 32'd5);
    chk("err_count_l3", 32'(err_seen[1]), 32'd0);
    chk("done_count_l3", 32'(done_seen[1]), 32'd1);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
